queue_xfer_ctrl: RTL

//  Single-clock sequencer between the deserializer (producer) and the 8-entry byte queue.

---
 rtl/queue_xfer_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 37 +++
 rtl/queue_xfer_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/queue_xfer_pkg.sv
// Shared types and default sizing for the deserializer-to-queue sequencer.
package queue_xfer_pkg;

  localparam int DEPTH_DEF     = 8;    // queue capacity in bytes
  localparam int LEN_W_DEF     = 4;    // width of the occupancy input
  localparam int SETTLE_DEF    = 2;    // cycles between strobe and occupancy check
  localparam int STALL_MAX_DEF = 255;  // blocked cycles before stall is flagged

  typedef enum logic [2:0] {
    IDLE,
    ENQ,
    ENQ_SETTLE,
    ACK,
    WAIT_LOW,
    DEQ,
    DEQ_SETTLE,
    RDV
  } state_t;

  // Bit position of each requester in the arbiter request/grant vectors.
  typedef enum logic {
    REQ_WR = 1'b0,
    REQ_RD = 1'b1
  } requester_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. A lone request is granted directly; on
// contention the requester that did not win the previous contention wins.
module rr_arb2
  import queue_xfer_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant,
  input  logic       i_advance
);

  requester_e r_last;

  // Grant selection: priority rotates only when both sides are asking.
  always_comb begin
    // NOTE: default assigned first so every path drives o_grant and no latch is inferred.
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (r_last == REQ_RD) ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  // Remember the winner of the last contention; starts as if a read won last.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= REQ_RD;
    end else if (i_advance && (i_req == 2'b11)) begin
      // NOTE: non-blocking assignment for every sequential state update.
      r_last <= o_grant[REQ_RD] ? REQ_RD : REQ_WR;
    end
  end

endmodule

// File: rtl/queue_xfer_ctrl.sv
// Sequencer between the deserializer and the byte queue: converts the
// producer's level data_ready and the consumer's read pulses into
// one-cycle enqueue/dequeue strobes, verifies the queue occupancy after
// each strobe, and applies back-pressure when the queue is full.
module queue_xfer_ctrl
  import queue_xfer_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int SETTLE    = SETTLE_DEF,
  parameter int STALL_MAX = STALL_MAX_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_des_ready,
  output logic             o_des_ack,
  input  logic [LEN_W-1:0] i_q_len,
  output logic             o_q_enqueue,
  output logic             o_q_dequeue,
  input  logic             i_rd_req,
  output logic             o_rd_valid,
  output logic             o_rd_empty_err,
  output logic             o_full,
  output logic             o_stall_flag,
  output logic             o_len_err
);

  localparam logic [LEN_W-1:0] DEPTH_L     = LEN_W'(DEPTH);
  localparam logic [2:0]       SETTLE_LAST = 3'(SETTLE - 1);
  localparam logic [7:0]       STALL_LAST  = 8'(STALL_MAX - 1);
  localparam logic [7:0]       STALL_SAT   = 8'(STALL_MAX);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rd_pend;
  logic             r_armed;
  logic [LEN_W-1:0] r_exp;
  logic [2:0]       r_settle_cnt;
  logic [7:0]       r_stall_cnt;
  logic             r_full;
  logic             r_stall_flag;
  logic             r_len_err;

  logic             w_in_idle;
  logic             w_wr_ok;
  logic             w_rd_ok;
  logic             w_empty_err;
  logic             w_blocked;
  logic             w_settling;
  logic             w_settle_done;
  logic [1:0]       w_grant;

  assign w_in_idle     = (r_state == IDLE);
  assign w_wr_ok       = i_des_ready & r_armed & (i_q_len < DEPTH_L);
  assign w_rd_ok       = r_rd_pend & (i_q_len != '0);
  assign w_empty_err   = w_in_idle & r_rd_pend & (i_q_len == '0);
  assign w_blocked     = w_in_idle & i_des_ready & r_armed & (i_q_len == DEPTH_L);
  assign w_settling    = (r_state == ENQ_SETTLE) || (r_state == DEQ_SETTLE);
  assign w_settle_done = (r_settle_cnt == SETTLE_LAST);

  rr_arb2 u_arb (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     ({w_rd_ok, w_wr_ok}),
    .o_grant   (w_grant),
    .i_advance (w_in_idle)
  );

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and Moore strobe decode.
  always_comb begin
    w_state_nxt    = r_state;
    o_q_enqueue    = 1'b0;
    o_q_dequeue    = 1'b0;
    o_des_ack      = 1'b0;
    o_rd_valid     = 1'b0;
    o_rd_empty_err = w_empty_err;
    // NOTE: strobes decode straight from the async-reset state, so they fall the moment reset asserts.
    case (r_state)
      IDLE: begin
        if (w_grant[REQ_WR])      w_state_nxt = ENQ;
        else if (w_grant[REQ_RD]) w_state_nxt = DEQ;
      end
      ENQ: begin
        o_q_enqueue = 1'b1;
        w_state_nxt = ENQ_SETTLE;
      end
      ENQ_SETTLE: if (w_settle_done) w_state_nxt = ACK;
      ACK: begin
        o_des_ack   = 1'b1;
        w_state_nxt = WAIT_LOW;
      end
      WAIT_LOW: w_state_nxt = IDLE;
      DEQ: begin
        o_q_dequeue = 1'b1;
        w_state_nxt = DEQ_SETTLE;
      end
      DEQ_SETTLE: if (w_settle_done) w_state_nxt = RDV;
      RDV: begin
        o_rd_valid  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request bookkeeping: pending read, producer re-arm, expected occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_pend <= 1'b0;
      r_armed   <= 1'b1;
      r_exp     <= '0;
    end else begin
      // A fresh pulse wins over the clear so a request landing on DEQ is not lost.
      if (i_rd_req)                              r_rd_pend <= 1'b1;
      else if ((r_state == DEQ) || w_empty_err)  r_rd_pend <= 1'b0;

      // Disarm on ack until the producer drops data_ready, so one held byte enqueues once.
      if (r_state == ACK)   r_armed <= 1'b0;
      else if (!i_des_ready) r_armed <= 1'b1;

      if (r_state == ENQ)      r_exp <= i_q_len + LEN_W'(1);
      else if (r_state == DEQ) r_exp <= i_q_len - LEN_W'(1);
    end
  end

  // Settle timer and sticky occupancy-mismatch flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_settle_cnt <= '0;
      r_len_err    <= 1'b0;
    end else begin
      if ((r_state == ENQ) || (r_state == DEQ)) r_settle_cnt <= '0;
      else if (w_settling && !w_settle_done)    r_settle_cnt <= r_settle_cnt + 3'd1;

      if (w_settling && w_settle_done && (i_q_len != r_exp)) r_len_err <= 1'b1;
    end
  end

  // Back-pressure accounting: saturating blocked-cycle count and full flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt  <= '0;
      r_stall_flag <= 1'b0;
      r_full       <= 1'b0;
    end else begin
      r_full <= (i_q_len == DEPTH_L);
      if (r_state == ENQ) begin
        r_stall_cnt <= '0;
      end else if (w_blocked && (r_stall_cnt != STALL_SAT)) begin
        r_stall_cnt <= r_stall_cnt + 8'd1;
        if (r_stall_cnt == STALL_LAST) r_stall_flag <= 1'b1;
      end
    end
  end

  assign o_full       = r_full;
  assign o_stall_flag = r_stall_flag;
  assign o_len_err    = r_len_err;

endmodule
